fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequencer for the instruction-fetch stage of the vector ASIP pipeline. Owns the program counter, drives the combinational-read instruction memory address, and holds the IF/ID pipeline register. It chooses the next PC each cycle from four sources: sequential increment, decode-stage jump, execute-stage taken branch, or hold (stall/halt). It emits squash signals so wrong-path instructions are cancelled.

Parameters:
PC_W, 8, program counter / ROM address width
INSTR_W, 16, instruction width
PC_STEP, 4, sequential PC increment
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
instr_i  input  INSTR_W  instruction memory read data for address pc_o (same-cycle, combinational)
stall_i  input  1  hazard unit: hold IF and IF/ID this cycle
jmp_i  input  1  decode: unconditional jump in IF/ID instruction
jmp_target_i  input  PC_W  jump destination
br_taken_i  input  1  execute: conditional branch resolved taken
br_target_i  input  PC_W  branch destination
halt_i  input  1  decode: halt instruction in IF/ID
resume_i  input  1  external restart from HALT
pc_o  output  PC_W  current fetch address to instruction memory
instr_o  output  INSTR_W  IF/ID instruction
instr_pc_o  output  PC_W  PC of instr_o
instr_valid_o  output  1  instr_o is a live instruction
flush_ex_o  output  1  load a bubble into ID/EX this cycle
halted_o  output  1  controller in HALT

Behaviour:
- FSM states: BOOT, RUN, HALT. Reset (reset==0 at a clock edge) -> BOOT, pc=RESET_PC, instr_o=0, instr_pc_o=0, instr_valid_o=0, halted_o=0. flush_ex_o is combinational and is 0 in BOOT.
- BOOT: lasts exactly one cycle. Inputs are ignored and pc holds. Next state is RUN. First valid instruction appears on instr_o one cycle after entering RUN (2 cycles after reset release).
- RUN, per-cycle priority (highest first):
  1. br_taken_i: pc<=br_target_i, instr_valid_o<=0 (squash fetched wrong-path instr), flush_ex_o=1 (kills instr in ID). Overrides stall_i, jmp_i and halt_i in the same cycle.
  2. stall_i: pc, instr_o, instr_pc_o, instr_valid_o hold. jmp_i and halt_i are ignored because the decoding instruction is held and re-presents them.
  3. halt_i && instr_valid_o: -> HALT, pc holds (points past halt), instr_valid_o<=0.
  4. jmp_i && instr_valid_o: pc<=jmp_target_i, instr_valid_o<=0.
  5. otherwise: instr_o<=instr_i, instr_pc_o<=pc, instr_valid_o<=1, pc<=pc+PC_STEP.
- flush_ex_o = br_taken_i && state==RUN, combinational.
- jmp_i/halt_i with instr_valid_o==0 are ignored (bubble cannot jump).
- PC arithmetic is modulo 2^PC_W: 252+4 -> 0 at PC_W=8. Targets are used unaligned-as-given, with no checking.
- HALT: halted_o=1, all inputs except resume_i are ignored. resume_i -> RUN, and fetch continues from held pc with no extra bubble beyond the standard one-cycle fill.
- Reset mid-operation (any state): immediate return to BOOT values at that edge. Reset has priority over every input.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs stall_cnt_o[15:0] and redirect_cnt_o[15:0], both cleared by reset.
  - stall_cnt_o increments on each RUN cycle with stall_i && !br_taken_i.
  - redirect_cnt_o increments on each taken branch or accepted jump.
  - Both saturate at 16'hFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (BOOT, RUN, HALT)
  - FETCH_PC_W, FETCH_INSTR_W, FETCH_PC_STEP
  - NOP_INSTR (16'h0000, the value loaded into instr_o on squash)
- One natural sub-module: fetch_next_pc. It is the combinational priority mux producing the next PC and the squash/flush decisions from state plus inputs. The top holds the FSM and registers.

Test Plan:
- Reset release, instr_i=ROM[pc], no events:
  - pc_o sequence 0,0,4,8,12.
  - instr_valid_o first high in cycle 2 with instr_pc_o=0.
  - Continuing to pc=252 then wrapping to 0.
- At pc=8 assert stall_i for 3 cycles:
  - pc_o stays 8.
  - instr_o/instr_pc_o=4 held.
  - Fetch resumes 12 on release.
- br_taken_i=1, br_target_i=0x40 together with stall_i=1 and jmp_i=1:
  - flush_ex_o=1 that cycle.
  - Next cycle pc_o=0x40 and instr_valid_o=0.
  - Following cycle instr_pc_o=0x40 valid.
- jmp_i=1, jmp_target_i=0x20 with valid instr:
  - pc_o=0x20 next cycle, one bubble, flush_ex_o=0.
  - Repeat with instr_valid_o=0: jump ignored.
- halt_i with valid instr at instr_pc_o=0x10 (pc=0x14):
  - HALT, halted_o=1, pc_o=0x14 held for 5 cycles despite jmp_i.
  - resume_i -> fetch 0x14, 0x18.
- reset pulled low for one cycle during stall and during HALT:
  - All outputs return to reset values, BOOT for one cycle.
  - Perf counters (if FETCH_PERF_CNT_EN) read 0.
  - After 3 stalls + 1 branch they read 3/1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The optional FETCH_PERF_CNT_EN build uses sat_inc16 for its counters.
package fetch_pkg;

   localparam int FETCH_PC_W    = 8;
   localparam int FETCH_INSTR_W = 16;
   localparam int FETCH_PC_STEP = 4;

   // Value loaded into the IF/ID instruction register whenever its entry is squashed.
   localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // The action chosen for this cycle, in priority order: branch, hold, halt, jump, sequential fetch.
   typedef enum logic [2:0] {
      SEL_HOLD = 3'd0,
      SEL_SEQ  = 3'd1,
      SEL_JMP  = 3'd2,
      SEL_BR   = 3'd3,
      SEL_HALT = 3'd4
   } fetch_sel_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch controller (master) and the surrounding pipeline and ROM (slave).
// The counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_if import fetch_pkg::*; #(
   parameter int PC_W    = FETCH_PC_W,
   parameter int INSTR_W = FETCH_INSTR_W
);
   // instr_valid marks instr/instr_pc as a live IF/ID entry. stall acts as
   // not-ready from decode: while it is high the entry and pc are held unchanged.
   logic [INSTR_W-1:0] rdata;
   logic               stall;
   logic               jmp;
   logic [PC_W-1:0]    jmp_target;
   logic               br_taken;
   logic [PC_W-1:0]    br_target;
   logic               halt;
   logic               resume;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               flush_ex;
   logic               halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]        stall_cnt;
   logic [15:0]        redirect_cnt;
`endif

   modport master (
      input  rdata, stall, jmp, jmp_target, br_taken, br_target, halt, resume,
      output pc, instr, instr_pc, instr_valid, flush_ex, halted
`ifdef FETCH_PERF_CNT_EN
      , output stall_cnt, redirect_cnt
`endif
   );

   modport slave (
      output rdata, stall, jmp, jmp_target, br_taken, br_target, halt, resume,
      input  pc, instr, instr_pc, instr_valid, flush_ex, halted
`ifdef FETCH_PERF_CNT_EN
      , input stall_cnt, redirect_cnt
`endif
   );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational priority mux: picks the next PC, the per-cycle action and the ID/EX flush
// from the controller state and the pipeline event inputs.
module fetch_next_pc import fetch_pkg::*; #(
   parameter int PC_W    = FETCH_PC_W,
   parameter int PC_STEP = FETCH_PC_STEP
) (
   input  fetch_state_t    state,
   input  logic [PC_W-1:0] pc,
   input  logic            instr_valid,
   input  logic            stall,
   input  logic            jmp,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt,
   output logic [PC_W-1:0] pc_next,
   output fetch_sel_t      sel,
   output logic            flush_ex
);

   always_comb begin
      pc_next  = pc;
      sel      = SEL_HOLD;
      flush_ex = 1'b0;
      if (state == RUN) begin
         // A resolved branch beats everything: the decode-stage event belongs to a wrong-path instruction.
         if (br_taken) begin
            pc_next  = br_target;
            sel      = SEL_BR;
            flush_ex = 1'b1;
         end else if (stall) begin
            sel = SEL_HOLD;
         end else if (halt && instr_valid) begin
            sel = SEL_HALT;
         end else if (jmp && instr_valid) begin
            pc_next = jmp_target;
            sel     = SEL_JMP;
         end else begin
            pc_next = pc + PC_W'(PC_STEP);
            sel     = SEL_SEQ;
         end
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC register, BOOT/RUN/HALT FSM and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall and redirect counters.
module fetch_controller import fetch_pkg::*; #(
   parameter int PC_W     = FETCH_PC_W,
   parameter int INSTR_W  = FETCH_INSTR_W,
   parameter int PC_STEP  = FETCH_PC_STEP,
   parameter int RESET_PC = 0
) (
   input  logic         clk,
   input  logic         reset,
   fetch_if.master      bus,
   output fetch_state_t dbg_state
);

   fetch_state_t       state;
   fetch_state_t       state_next;
   fetch_sel_t         sel;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_next;
   logic [PC_W-1:0]    instr_pc;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               flush_ex;

   fetch_next_pc #(
      .PC_W    (PC_W),
      .PC_STEP (PC_STEP)
   ) u_next_pc (
      .state       (state),
      .pc          (pc),
      .instr_valid (instr_valid),
      .stall       (bus.stall),
      .jmp         (bus.jmp),
      .jmp_target  (bus.jmp_target),
      .br_taken    (bus.br_taken),
      .br_target   (bus.br_target),
      .halt        (bus.halt),
      .pc_next     (pc_next),
      .sel         (sel),
      .flush_ex    (flush_ex)
   );

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = RUN;
         RUN:     if (sel == SEL_HALT) state_next = HALT;
         HALT:    if (bus.resume) state_next = RUN;
         default: state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= BOOT;
         pc          <= PC_W'(RESET_PC);
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         case (sel)
            SEL_SEQ: begin
               instr       <= bus.rdata;
               instr_pc    <= pc;
               instr_valid <= 1'b1;
            end
            // Squash: instr_pc is left as-is, only the entry's validity and payload are cleared.
            SEL_JMP, SEL_BR, SEL_HALT: begin
               instr       <= INSTR_W'(NOP_INSTR);
               instr_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] redirect_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (state == RUN && bus.stall && !bus.br_taken) stall_cnt <= sat_inc16(stall_cnt);
         if (sel == SEL_BR || sel == SEL_JMP) redirect_cnt <= sat_inc16(redirect_cnt);
      end
   end

   assign bus.stall_cnt    = stall_cnt;
   assign bus.redirect_cnt = redirect_cnt;
`endif

   assign bus.pc          = pc;
   assign bus.instr       = instr;
   assign bus.instr_pc    = instr_pc;
   assign bus.instr_valid = instr_valid;
   assign bus.flush_ex    = flush_ex;
   assign bus.halted      = (state == HALT);
   assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, PC wrap sequence and randomized
// stimulus against a cycle-level reference model with an expected fetch-stream queue.
module tb_fetch_controller;
   import fetch_pkg::*;

   localparam int PC_W = 8;
   localparam int IW   = 16;
   localparam int STEP = 4;

   typedef struct {
      bit rst_n;
      bit stall;
      bit jmp;
      int jt;
      bit br;
      int bt;
      bit halt;
      bit resume;
   } stim_t;

   typedef struct {
      stim_t s;
      int    pc;
      bit    valid;
      int    ipc;
      bit    flush;
      bit    halted;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before the end of the test");
      $fatal(1, "watchdog");
   end

   // ---------------- DUT ----------------
   fetch_if      bus ();
   fetch_state_t dbg_state;
   logic [IW-1:0] rom [256];

   fetch_controller #(
      .PC_W     (PC_W),
      .INSTR_W  (IW),
      .PC_STEP  (STEP),
      .RESET_PC (0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   assign bus.rdata = rom[bus.pc];

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [PC_W+IW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 = boot, 1 = run, 2 = halt
   int          m_mode  = 0;
   int          m_pc    = 0;
   int          m_ipc   = 0;
   bit          m_valid = 0;
   logic [IW-1:0] m_instr = '0;
   int          m_scnt  = 0;
   int          m_rcnt  = 0;
   bit          m_fresh = 0;
   stim_t       cur;

   task automatic model_update(input stim_t s);
      m_fresh = 0;
      if (!s.rst_n) begin
         m_mode = 0; m_pc = 0; m_ipc = 0; m_valid = 0; m_instr = '0;
         m_scnt = 0; m_rcnt = 0;
         exp_q.delete();
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         if (s.resume) m_mode = 1;
      end else begin
         if (s.br) begin
            m_pc = s.bt % 256; m_valid = 0;
            if (m_rcnt < 65535) m_rcnt++;
         end else if (s.stall) begin
            if (m_scnt < 65535) m_scnt++;
         end else if (s.halt && m_valid) begin
            m_mode = 2; m_valid = 0;
         end else if (s.jmp && m_valid) begin
            m_pc = s.jt % 256; m_valid = 0;
            if (m_rcnt < 65535) m_rcnt++;
         end else begin
            m_instr = rom[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + STEP) % 256;
            m_fresh = 1;
            exp_q.push_back({PC_W'(m_ipc), m_instr});
         end
      end
   endtask

   task automatic model_check();
      logic [PC_W+IW-1:0] e;
      check("pc", bus.pc, m_pc);
      check("instr_valid", bus.instr_valid, m_valid);
      check("instr_pc", bus.instr_pc, m_ipc);
      if (m_valid) check("instr", bus.instr, m_instr);
      check("halted", bus.halted, m_mode == 2);
      check("flush_ex", bus.flush_ex, cur.br && m_mode == 1);
      if (m_fresh) begin
         if (exp_q.size() == 0) begin
            check("stream_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("stream", {bus.instr_pc, bus.instr}, e);
         end
      end
`ifdef FETCH_PERF_CNT_EN
      check("stall_cnt", bus.stall_cnt, m_scnt);
      check("redirect_cnt", bus.redirect_cnt, m_rcnt);
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input stim_t s);
      @(negedge clk);
      cur            = s;
      reset          = s.rst_n;
      bus.stall      = s.stall;
      bus.jmp        = s.jmp;
      bus.jmp_target = 8'(s.jt);
      bus.br_taken   = s.br;
      bus.br_target  = 8'(s.bt);
      bus.halt       = s.halt;
      bus.resume     = s.resume;
      #1;
   endtask

   task automatic edge_step(input stim_t s);
      @(posedge clk);
      model_update(s);
   endtask

   function automatic stim_t idle(input bit rst_n);
      stim_t s;
      s = '{rst_n: rst_n, stall: 0, jmp: 0, jt: 0, br: 0, bt: 0, halt: 0, resume: 0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      drive(s);
      model_check();
      edge_step(s);
   endtask

   task automatic do_reset();
      drive(idle(0));
      edge_step(idle(0));
      step(idle(0));
   endtask

   function automatic vec_t v(input bit rst_n, stall, jmp, input int jt, input bit br,
                              input int bt, input bit halt, resume,
                              input int pc, input bit valid, input int ipc,
                              input bit flush, halted);
      vec_t r;
      r.s = '{rst_n: rst_n, stall: stall, jmp: jmp, jt: jt, br: br, bt: bt, halt: halt, resume: resume};
      r.pc = pc; r.valid = valid; r.ipc = ipc; r.flush = flush; r.halted = halted;
      return r;
   endfunction

   vec_t vecs[29];

   initial begin
      stim_t s;
      int    k;

      for (int a = 0; a < 256; a++) rom[a] = 16'($urandom_range(16'hFFFF));
      cur = idle(0);

      //        rst st jmp jt    br bt    hlt res   pc    vld ipc   fl hl
      vecs[0]  = v(1, 0, 1, 8'h20, 1, 8'h40, 0, 0,   8'h00, 0, 8'h00, 0, 0);
      vecs[1]  = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h00, 0, 8'h00, 0, 0);
      vecs[2]  = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h04, 1, 8'h00, 0, 0);
      vecs[3]  = v(1, 1, 0, 0,     0, 0,     0, 0,   8'h08, 1, 8'h04, 0, 0);
      vecs[4]  = v(1, 1, 1, 8'h30, 0, 0,     0, 0,   8'h08, 1, 8'h04, 0, 0);
      vecs[5]  = v(1, 1, 0, 0,     0, 0,     1, 0,   8'h08, 1, 8'h04, 0, 0);
      vecs[6]  = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h08, 1, 8'h04, 0, 0);
      vecs[7]  = v(1, 1, 1, 8'h20, 1, 8'h40, 0, 0,   8'h0C, 1, 8'h08, 1, 0);
      vecs[8]  = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h40, 0, 8'h08, 0, 0);
      vecs[9]  = v(1, 0, 1, 8'h20, 0, 0,     0, 0,   8'h44, 1, 8'h40, 0, 0);
      vecs[10] = v(1, 0, 1, 8'h80, 0, 0,     0, 0,   8'h20, 0, 8'h40, 0, 0);
      vecs[11] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h24, 1, 8'h20, 0, 0);
      vecs[12] = v(1, 0, 1, 8'h10, 0, 0,     0, 0,   8'h28, 1, 8'h24, 0, 0);
      vecs[13] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h10, 0, 8'h24, 0, 0);
      vecs[14] = v(1, 0, 0, 0,     0, 0,     1, 0,   8'h14, 1, 8'h10, 0, 0);
      vecs[15] = v(1, 0, 1, 8'h80, 1, 8'h40, 0, 0,   8'h14, 0, 8'h10, 0, 1);
      vecs[16] = v(1, 0, 1, 8'h80, 0, 0,     1, 0,   8'h14, 0, 8'h10, 0, 1);
      vecs[17] = v(1, 1, 1, 8'h80, 0, 0,     0, 0,   8'h14, 0, 8'h10, 0, 1);
      vecs[18] = v(1, 0, 1, 8'h80, 0, 0,     0, 0,   8'h14, 0, 8'h10, 0, 1);
      vecs[19] = v(1, 0, 1, 8'h80, 0, 0,     0, 0,   8'h14, 0, 8'h10, 0, 1);
      vecs[20] = v(1, 0, 0, 0,     0, 0,     0, 1,   8'h14, 0, 8'h10, 0, 1);
      vecs[21] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h14, 0, 8'h10, 0, 0);
      vecs[22] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h18, 1, 8'h14, 0, 0);
      vecs[23] = v(0, 1, 0, 0,     0, 0,     0, 0,   8'h1C, 1, 8'h18, 0, 0);
      vecs[24] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h00, 0, 8'h00, 0, 0);
      vecs[25] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h00, 0, 8'h00, 0, 0);
      vecs[26] = v(1, 0, 0, 0,     0, 0,     1, 0,   8'h04, 1, 8'h00, 0, 0);
      vecs[27] = v(0, 0, 0, 0,     0, 0,     0, 0,   8'h04, 0, 8'h00, 0, 1);
      vecs[28] = v(1, 0, 0, 0,     0, 0,     0, 0,   8'h00, 0, 8'h00, 0, 0);

      // ---- directed vector table ----
      do_reset();
      for (int i = 0; i < 29; i++) begin
         drive(vecs[i].s);
         model_check();
         check($sformatf("vec%0d_pc", i), bus.pc, vecs[i].pc);
         check($sformatf("vec%0d_valid", i), bus.instr_valid, vecs[i].valid);
         check($sformatf("vec%0d_instr_pc", i), bus.instr_pc, vecs[i].ipc);
         check($sformatf("vec%0d_flush", i), bus.flush_ex, vecs[i].flush);
         check($sformatf("vec%0d_halted", i), bus.halted, vecs[i].halted);
`ifdef FETCH_PERF_CNT_EN
         if (i == 0 || i == 24 || i == 28) begin
            check($sformatf("vec%0d_stall_cnt_reset", i), bus.stall_cnt, 0);
            check($sformatf("vec%0d_redir_cnt_reset", i), bus.redirect_cnt, 0);
         end
         if (i == 8) begin
            check("vec8_stall_cnt", bus.stall_cnt, 3);
            check("vec8_redir_cnt", bus.redirect_cnt, 1);
         end
`endif
         edge_step(vecs[i].s);
      end

      // ---- sequential run up to the top of the address space and wrap ----
      do_reset();
      k = 0;
      while (m_pc != 252 && k < 100) begin
         step(idle(1));
         k++;
      end
      drive(idle(1));
      model_check();
      check("wrap_pc_252", bus.pc, 252);
      edge_step(idle(1));
      drive(idle(1));
      model_check();
      check("wrap_pc_0", bus.pc, 0);
      check("wrap_instr_pc_252", bus.instr_pc, 252);
      check("wrap_instr_252", bus.instr, rom[252]);
      edge_step(idle(1));

      // ---- randomized stimulus ----
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         s.rst_n  = ($urandom_range(99) != 0);
         s.stall  = ($urandom_range(4) == 0);
         s.jmp    = ($urandom_range(5) == 0);
         s.jt     = int'($urandom_range(255));
         s.br     = ($urandom_range(7) == 0);
         s.bt     = int'($urandom_range(255));
         s.halt   = ($urandom_range(9) == 0);
         s.resume = ($urandom_range(3) == 0);
         step(s);
      end

      // ---- final report ----
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
